// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency cache slave port among NUM_REQ requesters.
// One transaction in flight: IDLE -> ISSUE -> WAIT (CAS_LATENCY cycles) -> DONE (ack).

module cache_port_arbiter_lane #(
  parameter int IW   = 1,
  parameter int LANE = 0
) (
  input  logic          done,
  input  logic [IW-1:0] win_idx,
  output logic          ack
);
  assign ack = done && (win_idx == IW'(LANE));
endmodule

module cache_port_arbiter #(
  parameter int              NUM_REQ     = 2,
  parameter int              OP_W        = 4,
  parameter int              ADDR_W      = 32,
  parameter int              DATA_W      = 8,
  parameter int              CAS_LATENCY = 1,
  parameter logic [OP_W-1:0] NOP_OP      = '0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      busy,
  output logic [OP_W-1:0]           cache_op,
  output logic [ADDR_W-1:0]         cache_addr,
  output logic [DATA_W-1:0]         cache_wdata,
  output logic                      cache_data_oe,
  input  logic [DATA_W-1:0]         cache_rdata
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (CAS_LATENCY > 1) ? $clog2(CAS_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              read;
  } txn_t;

  state_t state, state_nxt;
  txn_t   lat, cand;

  logic [IW-1:0] rr_ptr, win_idx, grant_idx;
  logic [CW-1:0] wait_cnt;
  logic          grant_found, st_done;

  logic [NUM_REQ-1:0][OP_W-1:0]   op_arr;
  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_arr;
  logic [NUM_REQ-1:0][DATA_W-1:0] wdata_arr;

  assign op_arr    = req_op;
  assign addr_arr  = req_addr;
  assign wdata_arr = req_wdata;

  // First active requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int c;
    c           = 0;
    grant_found = 1'b0;
    grant_idx   = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = int'(rr_ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!grant_found && req_valid[IW'(c)]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(c);
      end
    end
  end

  always_comb begin
    cand       = '0;
    cand.op    = op_arr[grant_idx];
    cand.addr  = addr_arr[grant_idx];
    cand.wdata = wdata_arr[grant_idx];
    cand.read  = req_read[grant_idx];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_found) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != IDLE);
    st_done       = (state == DONE);
    cache_op      = NOP_OP;
    cache_data_oe = 1'b0;
    if (state == ISSUE) begin
      cache_op      = lat.op;
      cache_data_oe = !lat.read;
    end
  end

  // Address and write data stay parked on the bus between issues.
  assign cache_addr  = lat.addr;
  assign cache_wdata = lat.wdata;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lat       <= '0;
      win_idx   <= '0;
      rr_ptr    <= '0;
      wait_cnt  <= '0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (grant_found) begin
          win_idx <= grant_idx;
          lat     <= cand;
        end
        ISSUE: wait_cnt <= CW'(CAS_LATENCY - 1);
        WAIT: begin
          if (wait_cnt == '0) begin
            if (lat.read) rsp_rdata <= cache_rdata;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        DONE: rr_ptr <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    cache_port_arbiter_lane #(.IW(IW), .LANE(g)) u_lane (
      .done    (st_done),
      .win_idx (win_idx),
      .ack     (req_ack[g])
    );
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: 3-requester CAS=1 instance plus a 2-requester CAS=3 instance.
module tb_cache_port_arbiter;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [2:0]  req_valid, req_read, req_ack;
  logic [11:0] req_op;
  logic [95:0] req_addr;
  logic [23:0] req_wdata;
  logic [7:0]  rsp_rdata, cache_wdata, cache_rdata;
  logic        busy, cache_data_oe;
  logic [3:0]  cache_op;
  logic [31:0] cache_addr;

  logic [1:0]  b_req_valid, b_req_read, b_req_ack;
  logic [7:0]  b_req_op;
  logic [63:0] b_req_addr;
  logic [15:0] b_req_wdata;
  logic [7:0]  b_rsp_rdata, b_cache_wdata, b_cache_rdata;
  logic        b_busy, b_cache_data_oe;
  logic [3:0]  b_cache_op;
  logic [31:0] b_cache_addr;

  cache_port_arbiter #(.NUM_REQ(3), .CAS_LATENCY(1), .NOP_OP(4'hF)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_op(req_op),
    .req_read(req_read), .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack),
    .rsp_rdata(rsp_rdata), .busy(busy), .cache_op(cache_op), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_data_oe(cache_data_oe), .cache_rdata(cache_rdata)
  );

  cache_port_arbiter #(.NUM_REQ(2), .CAS_LATENCY(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .req_valid(b_req_valid), .req_op(b_req_op),
    .req_read(b_req_read), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_ack(b_req_ack),
    .rsp_rdata(b_rsp_rdata), .busy(b_busy), .cache_op(b_cache_op), .cache_addr(b_cache_addr),
    .cache_wdata(b_cache_wdata), .cache_data_oe(b_cache_data_oe), .cache_rdata(b_cache_rdata)
  );

  typedef struct {
    int         idx;
    logic       rd;
    logic [3:0] op;
    logic [31:0] addr;
    logic [7:0] wd;
    logic [7:0] slave;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [2:0] ack;
    logic [7:0] rd;
  } sb_t;

  vec_t vecs[6];
  sb_t  sb[$];
  int   total = 0;
  int   bad = 0;
  logic sb_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input int idx, input logic rd, input logic [3:0] op,
                           input logic [31:0] addr, input logic [7:0] wd);
    req_valid[idx]         = 1'b1;
    req_read[idx]          = rd;
    req_op[idx*4 +: 4]     = op;
    req_addr[idx*32 +: 32] = addr;
    req_wdata[idx*8 +: 8]  = wd;
  endtask

  // Scoreboard: every ack seen while enabled must match the oldest queued expectation.
  always @(negedge clock) begin
    if (sb_on && req_ack != 3'b000) begin
      check("ack_onehot", 32'($onehot(req_ack)), 32'd1);
      if (sb.size() == 0) begin
        check("sb_unexpected_ack", 32'(req_ack), 32'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("sb_ack", 32'(req_ack), 32'(e.ack));
        check("sb_rdata", 32'(rsp_rdata), 32'(e.rd));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int n, nack, acks;
    int ack_at[4];
    logic [2:0] ack_v[4];

    vecs[0] = '{0, 1'b1, 4'h1, 32'h0000_1234, 8'h00, 8'hA5, 8'hA5};
    vecs[1] = '{1, 1'b0, 4'h2, 32'h0000_00F0, 8'h3C, 8'h11, 8'hA5};
    vecs[2] = '{2, 1'b1, 4'h3, 32'hFFFF_FFFC, 8'h00, 8'h5A, 8'h5A};
    vecs[3] = '{1, 1'b1, 4'h1, 32'h0000_0000, 8'hEE, 8'hFF, 8'hFF};
    vecs[4] = '{0, 1'b0, 4'h2, 32'h8000_0000, 8'h00, 8'h22, 8'hFF};
    vecs[5] = '{2, 1'b1, 4'h1, 32'hDEAD_BEE0, 8'h77, 8'h00, 8'h00};

    // Reset held with random inputs on both instances.
    reset_n = 1'b0;
    repeat (4) begin
      @(negedge clock);
      req_valid = 3'($urandom); req_read = 3'($urandom); req_op = 12'($urandom);
      req_addr = {$urandom, $urandom, $urandom}; req_wdata = 24'($urandom);
      cache_rdata = 8'($urandom);
      b_req_valid = 2'($urandom); b_req_read = 2'($urandom); b_req_op = 8'($urandom);
      b_req_addr = {$urandom, $urandom}; b_req_wdata = 16'($urandom);
      b_cache_rdata = 8'($urandom);
    end
    check("rst_ack", 32'(req_ack), 0);
    check("rst_rdata", 32'(rsp_rdata), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_op", 32'(cache_op), 32'hF);
    check("rst_addr", cache_addr, 0);
    check("rst_wdata", 32'(cache_wdata), 0);
    check("rst_oe", 32'(cache_data_oe), 0);
    check("rst3_ack", 32'(b_req_ack), 0);
    check("rst3_busy", 32'(b_busy), 0);
    check("rst3_op", 32'(b_cache_op), 0);

    req_valid = '0; req_read = '0; req_op = '0; req_addr = '0; req_wdata = '0; cache_rdata = '0;
    b_req_valid = '0; b_req_read = '0; b_req_op = '0; b_req_addr = '0; b_req_wdata = '0;
    b_cache_rdata = '0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_busy_after_rst", 32'(busy), 0);

    // Table of single transactions, CAS_LATENCY=1.
    sb_on = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sb_t e;
      v = vecs[i];
      drive_req(v.idx, v.rd, v.op, v.addr, v.wd);
      cache_rdata = v.slave;
      e.ack = 3'(1 << v.idx);
      e.rd  = v.exp;
      sb.push_back(e);
      @(negedge clock);
      check("issue_busy", 32'(busy), 1);
      check("issue_op", 32'(cache_op), 32'(v.op));
      check("issue_addr", cache_addr, v.addr);
      check("issue_oe", 32'(cache_data_oe), 32'(!v.rd));
      if (!v.rd) check("issue_wdata", 32'(cache_wdata), 32'(v.wd));
      @(negedge clock);
      check("wait_op", 32'(cache_op), 32'hF);
      check("wait_oe", 32'(cache_data_oe), 0);
      check("wait_addr", cache_addr, v.addr);
      check("wait_ack", 32'(req_ack), 0);
      @(negedge clock);
      n = 0;
      while (req_ack == 3'b000 && n < 8) begin
        @(negedge clock);
        n++;
      end
      check("ack_latency_extra", n, 0);
      req_valid = '0;
      @(negedge clock);
      check("post_ack_busy", 32'(busy), 0);
      check("post_ack_ack", 32'(req_ack), 0);
    end
    check("sb_drained", sb.size(), 0);
    sb_on = 1'b0;

    // Reset asserted during WAIT abandons the transaction.
    drive_req(0, 1'b1, 4'h1, 32'h0000_0055, 8'h00);
    cache_rdata = 8'h77;
    @(negedge clock);
    @(negedge clock);
    check("rstw_busy_before", 32'(busy), 1);
    #1 reset_n = 1'b0;
    #1;
    check("rstw_async_op", 32'(cache_op), 32'hF);
    check("rstw_async_busy", 32'(busy), 0);
    req_valid = '0;
    acks = 0;
    repeat (3) begin
      @(negedge clock);
      if (req_ack != 3'b000) acks++;
    end
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clock);
      if (req_ack != 3'b000) acks++;
    end
    check("rstw_no_ack", acks, 0);
    check("rstw_rdata", 32'(rsp_rdata), 0);

    // Contention from reset: requesters 0 and 1 hold requests.
    reset_n = 1'b0;
    @(negedge clock);
    drive_req(0, 1'b1, 4'h1, 32'h0000_0100, 8'h00);
    drive_req(1, 1'b0, 4'h2, 32'h0000_0200, 8'h11);
    cache_rdata = 8'h99;
    @(negedge clock);
    reset_n = 1'b1;
    nack = 0;
    for (int t = 0; t < 40 && nack < 4; t++) begin
      @(negedge clock);
      if (req_ack != 3'b000) begin
        ack_v[nack]  = req_ack;
        ack_at[nack] = t;
        nack++;
      end
    end
    req_valid = '0;
    check("cont_ack_count", nack, 4);
    for (int k = 0; k < nack; k++) begin
      check("cont_order", 32'(ack_v[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k > 0) check("cont_spacing", ack_at[k] - ack_at[k-1], 4);
    end
    repeat (2) @(negedge clock);

    // Early withdrawal: requester 1 drops during WAIT, requester 0 arrives meanwhile.
    drive_req(1, 1'b1, 4'h1, 32'h0000_0300, 8'h00);
    cache_rdata = 8'h6B;
    @(negedge clock);
    drive_req(0, 1'b1, 4'h1, 32'h0000_0400, 8'h00);
    @(negedge clock);
    req_valid[1] = 1'b0;
    n = 0;
    while (req_ack == 3'b000 && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("wd_first_ack", 32'(req_ack), 32'h2);
    check("wd_first_rdata", 32'(rsp_rdata), 32'h6B);
    cache_rdata = 8'hC4;
    @(negedge clock);
    n = 0;
    while (req_ack == 3'b000 && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("wd_second_ack", 32'(req_ack), 32'h1);
    check("wd_second_rdata", 32'(rsp_rdata), 32'hC4);
    req_valid = '0;
    repeat (2) @(negedge clock);

    // CAS_LATENCY=3: slave data changes every cycle; cycle T+4 value must be captured.
    b_req_valid = 2'b01; b_req_read = 2'b01; b_req_op[3:0] = 4'h6;
    b_req_addr[31:0] = 32'h0000_0ABC; b_cache_rdata = 8'h40;
    for (int m = 1; m <= 7; m++) begin
      @(negedge clock);
      check("cas3_ack", 32'(b_req_ack), (m == 5) ? 32'd1 : 32'd0);
      check("cas3_op", 32'(b_cache_op), (m == 1) ? 32'h6 : 32'h0);
      check("cas3_busy", 32'(b_busy), (m <= 5) ? 32'd1 : 32'd0);
      if (m == 5) begin
        check("cas3_rdata", 32'(b_rsp_rdata), 32'h44);
        b_req_valid = 2'b00;
      end
      b_cache_rdata = 8'(8'h40 + m);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

Sequential arbiter that shares one cache slave port (operation / addr / data, fixed CAS latency) among NUM_REQ requesters, such as the instruction-fetch and data-access engines of the trace-driven simulator. It accepts one transaction at a time, chooses the winner round-robin, drives the cache bus for one issue cycle, waits CAS_LATENCY cycles, captures read data, and returns a one-cycle acknowledge to the winner.

## Interface
- NUM_REQ, 2, number of requesters (2..4)
- OP_W, 4, width of the cachepkg operation code
- ADDR_W, 32, address width (matches ADDRSPACE)
- DATA_W, 8, data width (matches WORD)
- CAS_LATENCY, 1, cycles from issue to valid read data (≥1)
- NOP_OP, 0, operation code driven when the bus is idle

- clock  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request; held until req_ack
- req_op  in  NUM_REQ*OP_W  operation code; slice i belongs to requester i
- req_read  in  NUM_REQ  1 means the op returns data (capture cache_rdata)
- req_addr  in  NUM_REQ*ADDR_W  request address
- req_wdata  in  NUM_REQ*DATA_W  write data, used when req_read=0
- req_ack  out  NUM_REQ  one-hot, one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data, valid while the matching req_ack is high
- busy  out  1  high in any state other than IDLE
- cache_op  out  OP_W  operation to the cache slave
- cache_addr  out  ADDR_W  address to the cache slave
- cache_wdata  out  DATA_W  write data to the cache slave
- cache_data_oe  out  1  drive-enable for the shared inout data bus
- cache_rdata  in  DATA_W  data returned by the cache slave

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req_valid is high, select the winner by round-robin: search upward from rr_ptr, wrapping modulo NUM_REQ.
  - Latch the winner's index, op, addr, wdata and read flag, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (1 cycle):
  - cache_op = latched op and cache_addr = latched addr.
  - If read=0: cache_wdata = latched wdata and cache_data_oe = 1.
  - Go to WAIT with wait_cnt = CAS_LATENCY-1.
- WAIT:
  - cache_op = NOP_OP; addr and wdata hold their values; cache_data_oe = 0.
  - Decrement wait_cnt each cycle.
  - In the cycle where wait_cnt == 0: if read=1, register cache_rdata into rsp_rdata; then go to DONE.
- DONE (1 cycle):
  - req_ack[winner] = 1.
  - rr_ptr = (winner+1) mod NUM_REQ.
  - Go to IDLE.
- rsp_rdata holds its last captured value after the ack. For writes it is left unchanged (the value is don't-care).
- The arbiter works only from latched values. If req_valid drops after the grant, the transaction still completes and the ack still pulses.
- A requester that drops req_valid before it is granted is simply not selected.
- A requester must deassert req_valid in the cycle after its ack. If it keeps req_valid high, that is treated as a new request.
- Only one transaction is ever in flight; there is no pipelining.

## Timing
- Reset values (asynchronous assert, released synchronously to clock):
  - state=IDLE, rr_ptr=0, wait_cnt=0
  - req_ack=0, rsp_rdata=0, busy=0
  - cache_op=NOP_OP, cache_addr=0, cache_wdata=0, cache_data_oe=0
- Reset asserted mid-transaction: the transaction is abandoned, no ack is issued, and the bus returns to NOP immediately.
- Latency:
  - Request sampled in IDLE at edge T puts the FSM in ISSUE during cycle T+1.
  - Read data is captured at the end of cycle T+1+CAS_LATENCY.
  - req_ack is high during cycle T+2+CAS_LATENCY.
  - Total request-to-ack latency is CAS_LATENCY+2 cycles. Back-to-back throughput is one transaction per CAS_LATENCY+3 cycles.
- Round-robin behaviour:
  - Simultaneous requests: the lowest index at or above rr_ptr wins.
  - With all requesters continuously active, grants rotate 0,1,…,NUM_REQ-1,0.
  - Starvation bound: NUM_REQ-1 transactions.
- busy is high from the first ISSUE cycle through the DONE cycle inclusive.
- req_ack is never high for more than one bit, and never for two consecutive cycles to the same requester without an intervening IDLE cycle.

## Test plan
- Reset: hold reset_n=0 with random inputs -> all outputs equal their reset values. Assert reset during WAIT -> no ack, and cache_op=NOP_OP asynchronously.
- Single read, CAS_LATENCY=1: requester 0, addr 32'h0000_1234, slave returns 8'hA5 -> cache_op valid exactly 1 cycle, ack[0] 3 cycles after the request edge, rsp_rdata=8'hA5.
- Single write: requester 1 writes 8'h3C to 32'h0000_00F0 -> cache_data_oe=1 and cache_wdata=8'h3C only in the ISSUE cycle, ack[1] pulses, rsp_rdata unchanged.
- Contention: requesters 0 and 1 both hold requests from reset -> grant order 0,1,0,1; exactly 4 cycles (CAS_LATENCY+3) between acks.
- Latency sweep: CAS_LATENCY=3 -> ack exactly 5 cycles after the request edge; data captured from the cycle-4 slave value.
- Early withdrawal: requester 1 drops req_valid during WAIT -> ack[1] still pulses; requester 0 is granted next.
